ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, the number of writable words in the target RAM.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port i_byte, input, 8, the incoming stream byte.
REQ-005 SHALL have port i_byte_valid, input, 1, meaning i_byte is valid.
REQ-006 SHALL have port o_byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-007 SHALL have port i_abort, input, 1, a synchronous abort of the current transfer.
REQ-008 SHALL have port o_set, output, 1, the RAM write strobe.
REQ-009 SHALL have port o_addr, output, 16, the RAM word address.
REQ-010 SHALL have port o_data, output, 32, the RAM write data.
REQ-011 SHALL have port i_rdata, input, 32, the RAM combinational read data at o_addr.
REQ-012 SHALL have port o_busy, output, 1, high whenever the FSM is outside S_HDR byte 0.
REQ-013 SHALL have port o_done, output, 1, a one-cycle pulse at the end of a transfer.
REQ-014 SHALL have port o_err, output, 1, a sticky error flag.

Function
REQ-015 SHALL accept a byte only on a cycle where i_byte_valid and o_byte_ready are both high.
REQ-016 SHALL implement FSM states S_HDR, S_DATA, S_WRITE, S_VERIFY and S_DONE.
REQ-017 SHALL, in S_HDR, hold o_byte_ready high and take 4 header bytes in order: addr[7:0], addr[15:8], cnt[7:0], cnt[15:8].
REQ-018 SHALL, on the 4th header byte, go to S_DONE if cnt==0 and to S_DATA otherwise.
REQ-019 SHALL, in S_DATA, hold o_byte_ready high and assemble each word little-endian: 1st byte to [7:0] through 4th byte to [31:24].
REQ-020 SHALL, on the 4th data byte, go to S_WRITE.
REQ-021 SHALL, in S_WRITE, hold o_byte_ready low for exactly one cycle with o_set=1, o_addr=current address and o_data=the assembled word.
REQ-022 SHALL assert o_set only in S_WRITE, and only for one cycle per word.
REQ-023 SHALL, if the current address is >= MEM_DEPTH, suppress o_set in S_WRITE, set o_err, and still consume the word.
REQ-024 SHALL increment the address after S_WRITE (or after S_VERIFY when that state is present), wrapping 16'hFFFF to 0.
REQ-025 SHALL decrement the remaining count after each word, go to S_DONE when it reaches 0, and return to S_DATA otherwise.
REQ-026 SHALL, in S_DONE, pulse o_done for one cycle with o_byte_ready low, then return to S_HDR.
REQ-027 SHALL, on i_abort high in any state, return to S_HDR next cycle without pulsing o_done.
REQ-028 SHALL, on abort, discard any partial header or word and suppress o_set that cycle.
REQ-029 SHALL give i_abort priority over a byte handshake in the same cycle; that byte is dropped.
REQ-030 SHALL clear o_err only by reset or on acceptance of the first header byte of a new transfer.
REQ-031 SHALL drive o_addr and o_data as registered outputs holding the last written values outside S_WRITE/S_VERIFY.
REQ-032 SHALL have a minimum transfer of 4+4*cnt accepted bytes; throughput is 1 word per 5 cycles (6 with verify).

Reset
REQ-033 SHALL, with i_rst_n low, asynchronously enter S_HDR at byte 0.
REQ-034 SHALL, with i_rst_n low, force o_byte_ready=0, o_set=0, o_addr=0, o_data=0, o_busy=0, o_done=0, o_err=0.
REQ-035 SHALL, after reset release, raise o_byte_ready on the first clock edge.
REQ-036 SHALL, on reset mid-transfer, abandon the transfer with no further writes.

Configuration
REQ-037 SHALL, with macro RAM_LOADER_VERIFY_EN defined, follow each performed write with one S_VERIFY cycle (o_set=0, same o_addr, o_byte_ready=0) that compares i_rdata to the written word and sets o_err on mismatch.
REQ-038 SHALL, without RAM_LOADER_VERIFY_EN, omit S_VERIFY and ignore i_rdata entirely.
REQ-039 SHALL skip S_VERIFY for writes suppressed by REQ-023.

Structure
REQ-040 SHALL place the FSM state enum, the header byte count (4) and the word byte count (4) in shared package proc_pkg.
REQ-041 SHALL be implemented as a single module with no sub-module; the word assembler is inline.

Verification
REQ-042 SHALL test a basic load: header 10 00 02 00, then bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678@0x10 and 0xDEADBEEF@0x11, then one o_done pulse with o_err=0.
REQ-043 SHALL test a zero count: header 00 00 00 00 -> no o_set and o_done pulsed 1 cycle after the 4th byte.
REQ-044 SHALL test a bounds check with MEM_DEPTH=256: header FF 00 02 00 -> word 0 written @0xFF, word 1 @0x100 suppressed, o_err=1, and o_done still pulsed.
REQ-045 SHALL test abort: i_abort after 2 data bytes -> no o_set or o_done, and a following header is accepted normally.
REQ-046 SHALL test verify with RAM_LOADER_VERIFY_EN and i_rdata stuck at 0: writing 0x00000001 sets o_err; writing 0x00000000 leaves o_err=0.
REQ-047 SHALL test reset: i_rst_n pulsed low mid-word -> all outputs 0 immediately and a fresh header is accepted afterwards.

Source files
------------

// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg -- shared definitions for the byte-stream RAM loader.
//
// Contents:
//   state_t      loader FSM states
//   HDR_BYTES    bytes in a transfer header (addr lo/hi, cnt lo/hi)
//   WORD_BYTES   bytes per 32-bit RAM word
//   is_last_byte helper: true when a byte index is the final one of a group
// ---------------------------------------------------------------------------
package proc_pkg;

   typedef enum logic [2:0] {
      S_HDR    = 3'd0,
      S_DATA   = 3'd1,
      S_WRITE  = 3'd2,
      S_VERIFY = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   // Both groups are four bytes long, so a 2-bit index covers either.
   function automatic logic is_last_byte(input logic [1:0] idx, input int total);
      return idx == 2'(total - 1);
   endfunction

endpackage

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader -- loads 32-bit words into a RAM from a byte stream.
//
// A transfer is a 4-byte little-endian header (start address, word count)
// followed by 4 little-endian bytes per word. Each assembled word is written
// with a one-cycle strobe; addresses at or beyond MEM_DEPTH are not written
// and raise the sticky error flag instead. The transfer ends with a
// one-cycle done pulse.
//
// Optional feature: define RAM_LOADER_VERIFY_EN to read every performed write
// back on the following cycle (S_VERIFY) and flag a mismatch in o_err.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_byte        stream byte
//   i_byte_valid  i_byte is valid
//   o_byte_ready  loader accepts a byte this cycle
//   i_abort       synchronous abort of the current transfer
//   o_set         RAM write strobe
//   o_addr        RAM word address (registered)
//   o_data        RAM write data (registered)
//   i_rdata       RAM combinational read data at o_addr (verify build only)
//   o_busy        high whenever not waiting for header byte 0
//   o_done        one-cycle end-of-transfer pulse
//   o_err         sticky error flag
// ---------------------------------------------------------------------------
module ram_loader
   import proc_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   input  logic        i_abort,
   output logic        o_set,
   output logic [15:0] o_addr,
   output logic [31:0] o_data,
   input  logic [31:0] i_rdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   // 17 bits so that a full 64K-word RAM is still representable.
   localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

   state_t      state;
   state_t      state_nx;
   logic [1:0]  byte_idx;     // position inside the current header or word
   logic        ready_en;     // holds ready low until the first edge after reset
   logic [15:0] cur_addr;     // address of the word being assembled/written
   logic [15:0] remain;       // words still to be written in this transfer
   logic [23:0] word_lo;      // first three bytes of the word being assembled
   logic        in_range;
   logic        accept;
   logic        word_step;    // current word fully handled: advance addr/count

   assign in_range     = {1'b0, cur_addr} < DEPTH_LIMIT;
   assign o_byte_ready = ready_en && (state == S_HDR || state == S_DATA);
   // Abort wins over a handshake in the same cycle; that byte is dropped.
   assign accept       = i_byte_valid && o_byte_ready && !i_abort;
   assign o_busy       = (state != S_HDR) || (byte_idx != 2'd0);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_HDR;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and strobes
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      state_nx  = state;
      o_set     = 1'b0;
      o_done    = 1'b0;
      word_step = 1'b0;

      if (i_abort) begin
         state_nx = S_HDR;
      end else begin
         case (state)
            S_HDR: begin
               if (accept && is_last_byte(byte_idx, HDR_BYTES)) begin
                  state_nx = ({i_byte, remain[7:0]} == 16'd0) ? S_DONE : S_DATA;
               end
            end
            S_DATA: begin
               if (accept && is_last_byte(byte_idx, WORD_BYTES)) begin
                  state_nx = S_WRITE;
               end
            end
            S_WRITE: begin
               // Out-of-range words are consumed without a strobe.
               o_set = in_range;
`ifdef RAM_LOADER_VERIFY_EN
               if (in_range) begin
                  state_nx = S_VERIFY;
               end else begin
                  word_step = 1'b1;
               end
`else
               word_step = 1'b1;
`endif
            end
            S_VERIFY: begin
               word_step = 1'b1;
            end
            S_DONE: begin
               o_done   = 1'b1;
               state_nx = S_HDR;
            end
            default: begin
               state_nx = S_HDR;
            end
         endcase

         if (word_step) begin
            state_nx = (remain == 16'd1) ? S_DONE : S_DATA;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Header capture, word assembly, address/count tracking, error flag
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_en <= 1'b0;
         byte_idx <= 2'd0;
         cur_addr <= 16'd0;
         remain   <= 16'd0;
         word_lo  <= 24'd0;
         o_addr   <= 16'd0;
         o_data   <= 32'd0;
         o_err    <= 1'b0;
      end else begin
         ready_en <= 1'b1;

         if (i_abort) begin
            // Any partial header or word is discarded; stale bytes in the
            // holding registers are overwritten by the next transfer.
            byte_idx <= 2'd0;
         end else if (accept) begin
            if (state == S_HDR) begin
               byte_idx <= is_last_byte(byte_idx, HDR_BYTES) ? 2'd0 : byte_idx + 2'd1;
               case (byte_idx)
                  2'd0: begin
                     cur_addr[7:0] <= i_byte;
                     o_err         <= 1'b0;   // new transfer starts clean
                  end
                  2'd1:    cur_addr[15:8] <= i_byte;
                  2'd2:    remain[7:0]    <= i_byte;
                  default: remain[15:8]   <= i_byte;
               endcase
            end else begin
               byte_idx <= is_last_byte(byte_idx, WORD_BYTES) ? 2'd0 : byte_idx + 2'd1;
               case (byte_idx)
                  2'd0: word_lo[7:0]   <= i_byte;
                  2'd1: word_lo[15:8]  <= i_byte;
                  2'd2: word_lo[23:16] <= i_byte;
                  default: begin
                     // Outputs are loaded here so they are already valid
                     // during the S_WRITE cycle and hold afterwards.
                     o_addr <= cur_addr;
                     o_data <= {i_byte, word_lo};
                  end
               endcase
            end
         end

         if (state == S_WRITE && !i_abort && !in_range) begin
            o_err <= 1'b1;
         end

`ifdef RAM_LOADER_VERIFY_EN
         if (state == S_VERIFY && !i_abort && i_rdata != o_data) begin
            o_err <= 1'b1;
         end
`endif

         if (word_step) begin
            cur_addr <= cur_addr + 16'd1;   // wraps FFFF -> 0000
            remain   <= remain - 16'd1;
         end
      end
   end

`ifndef RAM_LOADER_VERIFY_EN
   // Read data has no consumer without the verify stage.
   logic unused_rdata;
   assign unused_rdata = ^i_rdata;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader -- self-checking bench for ram_loader.
//
// A transaction-level model turns each transfer (start address, word list)
// into the list of writes that must appear and the error flag expected at
// the done pulse. One negedge process compares every strobe and done pulse
// against it; directed sections pin cycle timing and flag values with
// literal expectations. Build with RAM_LOADER_VERIFY_EN to cover read-back.
// ---------------------------------------------------------------------------
module tb_ram_loader;

   localparam int DEPTH = 256;
`ifdef RAM_LOADER_VERIFY_EN
   localparam bit VERIFY_ON = 1'b1;
`else
   localparam bit VERIFY_ON = 1'b0;
`endif

   logic        i_clk;
   logic        i_rst_n;
   logic [7:0]  i_byte;
   logic        i_byte_valid;
   logic        o_byte_ready;
   logic        i_abort;
   logic        o_set;
   logic [15:0] o_addr;
   logic [31:0] o_data;
   logic [31:0] i_rdata;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   ram_loader #(.MEM_DEPTH(DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_byte       (i_byte),
      .i_byte_valid (i_byte_valid),
      .o_byte_ready (o_byte_ready),
      .i_abort      (i_abort),
      .o_set        (o_set),
      .o_addr       (o_addr),
      .o_data       (o_data),
      .i_rdata      (i_rdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Target RAM with combinational read port.
   logic [31:0] ram [0:DEPTH-1];
   bit          rd_stuck = 1'b0;
   always @(posedge i_clk) begin
      if (o_set && o_addr < DEPTH) ram[o_addr[7:0]] <= o_data;
   end
   assign i_rdata = rd_stuck ? 32'd0 : ((o_addr < DEPTH) ? ram[o_addr[7:0]] : 32'hA5A5_A5A5);

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      int          cyc;
   } obs_t;

   wr_t         exp_q[$];      // writes the model still expects
   obs_t        obs_q[$];      // writes seen in the current section
   logic [31:0] tx_words[$];   // payload for the next transfer
   bit          exp_err   = 1'b0;
   int          done_seen = 0;
   int          done_cyc  = 0;
   int          acc_cyc   = 0;
   int          gap_max   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Compare process: every strobe and done pulse against the model.
   // ------------------------------------------------------------------------
   always @(negedge i_clk) begin
      wr_t w;
      if (i_rst_n) begin
         if (o_set) begin
            obs_q.push_back('{o_addr, o_data, cyc});
            if (exp_q.size() == 0) begin
               check("unexpected_set", {31'd0, o_set}, 32'd0);
            end else begin
               w = exp_q.pop_front();
               check("wr_addr", {16'd0, o_addr}, {16'd0, w.addr});
               check("wr_data", o_data, w.data);
            end
            check("ready_low_in_write", {31'd0, o_byte_ready}, 32'd0);
         end
         if (o_done) begin
            done_seen++;
            done_cyc = cyc;
            check("err_at_done", {31'd0, o_err}, {31'd0, exp_err});
            check("ready_low_in_done", {31'd0, o_byte_ready}, 32'd0);
            check("no_set_with_done", {31'd0, o_set}, 32'd0);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (called at a negedge, return at a negedge)
   // ------------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      if (gap_max > 0) begin
         i_byte_valid = 1'b0;
         repeat ($urandom_range(0, gap_max)) @(negedge i_clk);
      end
      i_byte       = b;
      i_byte_valid = 1'b1;
      while (!o_byte_ready && waited < 40) begin
         @(negedge i_clk);
         waited++;
      end
      if (!o_byte_ready) begin
         check("ready_timeout", {31'd0, o_byte_ready}, 32'd1);
         i_byte_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;
      @(negedge i_clk);
      i_byte_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [15:0] addr, input logic [15:0] cnt);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(cnt[7:0]);
      send_byte(cnt[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   task automatic wait_done(input int start);
      for (int i = 0; i < 20 && done_seen == start; i++) @(negedge i_clk);
      @(negedge i_clk);
      check("done_pulse_count", done_seen, start + 1);
   endtask

   // Full transfer of tx_words[0 .. cnt-1]; the model derives expected
   // writes and the error flag from the address rules.
   task automatic send_transfer(input logic [15:0] addr, input logic [15:0] cnt);
      logic [15:0] a;
      bit          err;
      int          start;
      a   = addr;
      err = 1'b0;
      for (int i = 0; i < int'(cnt); i++) begin
         if (a < DEPTH) begin
            exp_q.push_back('{a, tx_words[i]});
            if (VERIFY_ON && rd_stuck && tx_words[i] != 32'd0) err = 1'b1;
         end else begin
            err = 1'b1;
         end
         a = a + 16'd1;
      end
      exp_err = err;
      start   = done_seen;
      obs_q.delete();
      send_hdr(addr, cnt);
      for (int i = 0; i < int'(cnt); i++) send_word(tx_words[i]);
      wait_done(start);
      check("writes_drained", exp_q.size(), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
      check({tag, "_set"},   {31'd0, o_set},        32'd0);
      check({tag, "_addr"},  {16'd0, o_addr},       32'd0);
      check({tag, "_data"},  o_data,                32'd0);
      check({tag, "_busy"},  {31'd0, o_busy},       32'd0);
      check({tag, "_done"},  {31'd0, o_done},       32'd0);
      check({tag, "_err"},   {31'd0, o_err},        32'd0);
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int start;
      logic [15:0] a;
      logic [15:0] n;
      int sel;

      i_rst_n      = 1'b0;
      i_byte       = 8'd0;
      i_byte_valid = 1'b0;
      i_abort      = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

      // Reset state and first-edge ready.
      #12;
      check_outputs_zero("rst");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check("ready_before_first_edge", {31'd0, o_byte_ready}, 32'd0);
      @(negedge i_clk);
      check("ready_after_first_edge", {31'd0, o_byte_ready}, 32'd1);

      // Basic load.
      tx_words.delete();
      tx_words.push_back(32'h1234_5678);
      tx_words.push_back(32'hDEAD_BEEF);
      send_transfer(16'h0010, 16'd2);
      check("basic_nwrites", obs_q.size(), 32'd2);
      check("basic_w0_addr", {16'd0, obs_q[0].addr}, 32'h0000_0010);
      check("basic_w0_data", obs_q[0].data, 32'h1234_5678);
      check("basic_w1_addr", {16'd0, obs_q[1].addr}, 32'h0000_0011);
      check("basic_w1_data", obs_q[1].data, 32'hDEAD_BEEF);
      check("basic_word_spacing", obs_q[1].cyc - obs_q[0].cyc, VERIFY_ON ? 32'd6 : 32'd5);
      check("basic_done_latency", done_cyc - obs_q[1].cyc, VERIFY_ON ? 32'd2 : 32'd1);
      check("basic_err", {31'd0, o_err}, 32'd0);
      check("basic_idle_busy", {31'd0, o_busy}, 32'd0);

      // Zero count.
      tx_words.delete();
      send_transfer(16'h0000, 16'd0);
      check("zero_done_latency", done_cyc - acc_cyc, 32'd1);
      check("zero_nwrites", obs_q.size(), 32'd0);
      check("zero_busy_after", {31'd0, o_busy}, 32'd0);

      // Bounds: second word lands at 0x100.
      tx_words.delete();
      tx_words.push_back($urandom);
      tx_words.push_back($urandom);
      send_transfer(16'h00FF, 16'd2);
      check("bounds_nwrites", obs_q.size(), 32'd1);
      check("bounds_w0_addr", {16'd0, obs_q[0].addr}, 32'h0000_00FF);
      check("bounds_err", {31'd0, o_err}, 32'd1);

      // Abort after two data bytes, with a byte offered in the abort cycle.
      start = done_seen;
      obs_q.delete();
      send_byte(8'h20);
      check("busy_mid_header", {31'd0, o_busy}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      i_byte       = 8'hCC;
      i_byte_valid = 1'b1;
      i_abort      = 1'b1;
      @(negedge i_clk);
      i_abort      = 1'b0;
      i_byte_valid = 1'b0;
      check("abort_busy_cleared", {31'd0, o_busy}, 32'd0);
      check("abort_ready", {31'd0, o_byte_ready}, 32'd1);
      repeat (6) @(negedge i_clk);
      check("abort_no_done", done_seen, start);
      check("abort_no_writes", obs_q.size(), 32'd0);
      tx_words.delete();
      tx_words.push_back(32'hCAFE_F00D);
      send_transfer(16'h0020, 16'd1);
      check("post_abort_addr", {16'd0, obs_q[0].addr}, 32'h0000_0020);
      check("post_abort_data", obs_q[0].data, 32'hCAFE_F00D);

      // Read-back with the RAM read port stuck at zero.
      rd_stuck = 1'b1;
      tx_words.delete();
      tx_words.push_back(32'h0000_0001);
      send_transfer(16'h0040, 16'd1);
      check("verify_one_err", {31'd0, o_err}, {31'd0, VERIFY_ON});
      tx_words.delete();
      tx_words.push_back(32'h0000_0000);
      send_transfer(16'h0041, 16'd1);
      check("verify_zero_err", {31'd0, o_err}, 32'd0);
      rd_stuck = 1'b0;

      // Randomised transfers, including address wrap and out-of-range tails.
      gap_max = 2;
      repeat (25) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = 16'hFFFE + 16'($urandom_range(0, 1));
         else if (sel == 1) a = 16'd250 + 16'($urandom_range(0, 8));
         else               a = 16'($urandom_range(0, 200));
         n = 16'($urandom_range(0, 4));
         tx_words.delete();
         for (int i = 0; i < int'(n); i++) tx_words.push_back($urandom);
         send_transfer(a, n);
      end
      gap_max = 0;

      // Reset in the middle of a word.
      obs_q.delete();
      send_hdr(16'h0030, 16'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check("midrst_ready_before_edge", {31'd0, o_byte_ready}, 32'd0);
      @(negedge i_clk);
      check("midrst_ready_after_edge", {31'd0, o_byte_ready}, 32'd1);
      check("midrst_no_writes", obs_q.size(), 32'd0);
      tx_words.delete();
      tx_words.push_back(32'h0BAD_F00D);
      tx_words.push_back(32'h7654_3210);
      send_transfer(16'h0050, 16'd2);
      check("post_rst_w1_data", obs_q[1].data, 32'h7654_3210);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
